// File: rtl/exp2_pkg.sv
// Shared types and defaults for the Experiment 2 truth-table sequencer.
package exp2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        DONE
    } state_t;

    localparam int          EXP2_N_IN           = 2;
    localparam logic [3:0]  EXP2_EXPECTED_TT    = 4'b1101;
    localparam int          EXP2_SETTLE_DEFAULT = 4;

endpackage

// File: rtl/exp2_settle_timer.sv
// Loadable down-counter; expired is high once SETTLE_CYC cycles have
// elapsed since the last load.
module exp2_settle_timer #(
    parameter int SETTLE_CYC = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic expired
);

    localparam int W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= W'(SETTLE_CYC - 1);
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expired = (cnt == '0);

endmodule

// File: rtl/exp2_tt_sequencer.sv
// Clocked truth-table sweep and checker for the Experiment 2 circuit.
// Optional early abort on first mismatch: EXP2_SEQ_STOP_ON_FAIL_EN.
module exp2_tt_sequencer
    import exp2_pkg::*;
#(
    parameter int                     N_IN        = EXP2_N_IN,
    parameter int                     SETTLE_CYC  = EXP2_SETTLE_DEFAULT,
    parameter logic [(2**N_IN)-1:0]   EXPECTED_TT = EXP2_EXPECTED_TT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    output logic [N_IN-1:0]        drv_vec,
    input  logic                   dut_out,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [(2**N_IN)-1:0]   result_tt,
    output logic [N_IN:0]          mismatch_cnt
`ifdef EXP2_SEQ_STOP_ON_FAIL_EN
    ,
    output logic [N_IN-1:0]        fail_idx
`endif
);

    state_t                 state, state_n;
    logic [N_IN-1:0]        idx, idx_n;
    logic [(2**N_IN)-1:0]   tt_n;
    logic [N_IN:0]          cnt_n;
    logic                   busy_n, done_n, pass_n;
    logic                   load, expired, miss, stop;
`ifdef EXP2_SEQ_STOP_ON_FAIL_EN
    logic [N_IN-1:0]        fail_n;
`endif

    exp2_settle_timer #(
        .SETTLE_CYC (SETTLE_CYC)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (load),
        .expired (expired)
    );

    // The driven vector is always the current table index.
    assign drv_vec = idx;
    assign miss    = (dut_out != EXPECTED_TT[idx]);

    always_comb begin
        state_n = state;
        idx_n   = idx;
        tt_n    = result_tt;
        cnt_n   = mismatch_cnt;
        busy_n  = busy;
        done_n  = done;
        pass_n  = pass;
        load    = 1'b0;
        stop    = 1'b0;
`ifdef EXP2_SEQ_STOP_ON_FAIL_EN
        fail_n  = fail_idx;
`endif
        unique case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_n = SETTLE;
                    idx_n   = '0;
                    tt_n    = '0;
                    cnt_n   = '0;
                    busy_n  = 1'b1;
                    done_n  = 1'b0;
                    pass_n  = 1'b0;
                    load    = 1'b1;
`ifdef EXP2_SEQ_STOP_ON_FAIL_EN
                    fail_n  = '0;
`endif
                end
            end
            SETTLE: begin
                if (expired) state_n = SAMPLE;
            end
            SAMPLE: begin
                tt_n[idx] = dut_out;
                if (miss) cnt_n = mismatch_cnt + 1'b1;
`ifdef EXP2_SEQ_STOP_ON_FAIL_EN
                stop = (idx == '1) || miss;
                if (miss) fail_n = idx;
`else
                stop = (idx == '1);
`endif
                if (stop) begin
                    state_n = DONE;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                    pass_n  = (cnt_n == '0);
                end else begin
                    state_n = SETTLE;
                    idx_n   = idx + 1'b1;
                    load    = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            idx          <= '0;
            result_tt    <= '0;
            mismatch_cnt <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            pass         <= 1'b0;
`ifdef EXP2_SEQ_STOP_ON_FAIL_EN
            fail_idx     <= '0;
`endif
        end else begin
            state        <= state_n;
            idx          <= idx_n;
            result_tt    <= tt_n;
            mismatch_cnt <= cnt_n;
            busy         <= busy_n;
            done         <= done_n;
            pass         <= pass_n;
`ifdef EXP2_SEQ_STOP_ON_FAIL_EN
            fail_idx     <= fail_n;
`endif
        end
    end

endmodule
